// File: rtl/fw_stream_tx.sv
// Firmware-load byte stream transmitter: frames AXI4-Stream bytes into a bank load, marks the bank, awaits ack.
// Optional FW_TX_CHECKSUM_EN adds csum_o and a two-byte checksum trailer ahead of the mark.
module fw_stream_tx #(
    parameter int unsigned MAX_LEN     = 4096,
    parameter int unsigned SETUP_CYC   = 8,
    parameter int unsigned HOLD_CYC    = 8,
    parameter int unsigned MARK_GAP    = 4,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic                      aclk_i,
    input  logic                      aclk_rst_i,
    input  logic                      run_active_i,
    input  logic                      start_i,
    input  logic                      bank_i,
    input  logic [7:0]                s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic                      fw_loading_o,
    output logic [7:0]                fw_tdata_o,
    output logic                      fw_tvalid_o,
    output logic [1:0]                fw_mark_o,
    input  logic [1:0]                fwmon_wr_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [2:0]                err_o,
`ifdef FW_TX_CHECKSUM_EN
    output logic [15:0]               csum_o,
`endif
    output logic [$clog2(MAX_LEN):0]  byte_cnt_o
);

    localparam int unsigned LEN_W   = $clog2(MAX_LEN) + 1;
    localparam int unsigned TMR_MAX = (ACK_TIMEOUT > SETUP_CYC)
                                      ? ((ACK_TIMEOUT > HOLD_CYC) ? ACK_TIMEOUT : HOLD_CYC)
                                      : ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned GAP_W   = $clog2(MARK_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STREAM, S_MARK, S_ACK, S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_tmr;
    logic [GAP_W-1:0]   r_gap;
    logic               r_bank;
    logic               w_fire_mark;
    logic               w_accept;
    logic               w_room;
    logic               w_gap_ok;
    logic               w_start_ok;
    logic               w_ack;
    logic               w_trl_done;

`ifdef FW_TX_CHECKSUM_EN
    logic [1:0]         r_trl;
    assign w_trl_done = (r_trl == 2'd2);
`else
    assign w_trl_done = 1'b1;
`endif

    assign w_accept   = (r_state == S_STREAM) && s_axis_tvalid && s_axis_tready;
    assign w_room     = (byte_cnt_o < LEN_W'(MAX_LEN));
    assign w_gap_ok   = (r_gap >= GAP_W'(MARK_GAP));
    assign w_start_ok = (r_state == S_IDLE) && start_i && !run_active_i;
    assign w_ack      = fwmon_wr_i[r_bank];

    // State register
    always_ff @(posedge aclk_i or posedge aclk_rst_i) begin
        if (aclk_rst_i) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next-state logic; the mark fires on the MARK->ACK transition
    always_comb begin
        w_state_nxt = r_state;
        w_fire_mark = 1'b0;
        case (r_state)
            S_IDLE:   if (w_start_ok) w_state_nxt = S_SETUP;
            S_SETUP:  if (r_tmr == TMR_W'(SETUP_CYC - 1)) w_state_nxt = S_STREAM;
            S_STREAM: if (w_accept && s_axis_tlast) w_state_nxt = S_MARK;
            S_MARK: begin
                if (w_trl_done && w_gap_ok) begin
                    w_fire_mark = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK:    if (w_ack || (r_tmr == TMR_W'(ACK_TIMEOUT - 1))) w_state_nxt = S_HOLD;
            S_HOLD:   if (r_tmr == TMR_W'(HOLD_CYC - 1)) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge aclk_i or posedge aclk_rst_i) begin
        if (aclk_rst_i) begin
            r_tmr         <= '0;
            r_gap         <= GAP_W'(MARK_GAP);
            r_bank        <= 1'b0;
            s_axis_tready <= 1'b0;
            fw_loading_o  <= 1'b0;
            fw_tdata_o    <= 8'h00;
            fw_tvalid_o   <= 1'b0;
            fw_mark_o     <= 2'b00;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 3'b000;
            byte_cnt_o    <= '0;
`ifdef FW_TX_CHECKSUM_EN
            csum_o        <= 16'h0000;
            r_trl         <= 2'd0;
`endif
        end else begin
            r_tmr         <= (w_state_nxt != r_state) ? '0 : r_tmr + TMR_W'(1);
            s_axis_tready <= (w_state_nxt == S_STREAM);
            fw_loading_o  <= (w_state_nxt != S_IDLE);
            busy_o        <= (w_state_nxt != S_IDLE);
            done_o        <= (r_state == S_HOLD) && (w_state_nxt == S_IDLE);
            fw_mark_o     <= w_fire_mark ? {r_bank, ~r_bank} : 2'b00;
            fw_tvalid_o   <= 1'b0;

            if (w_fire_mark)   r_gap <= '0;
            else if (!w_gap_ok) r_gap <= r_gap + GAP_W'(1);

            if (w_start_ok) begin
                r_bank     <= bank_i;
                err_o      <= 3'b000;
                byte_cnt_o <= '0;
`ifdef FW_TX_CHECKSUM_EN
                csum_o     <= 16'h0000;
                r_trl      <= 2'd0;
`endif
            end else if ((r_state == S_IDLE) && start_i) begin
                err_o[0] <= 1'b1;
            end

            // Bytes beyond MAX_LEN are drained but not forwarded
            if (w_accept) begin
                if (w_room) begin
                    fw_tdata_o  <= s_axis_tdata;
                    fw_tvalid_o <= 1'b1;
                    byte_cnt_o  <= byte_cnt_o + LEN_W'(1);
`ifdef FW_TX_CHECKSUM_EN
                    csum_o      <= csum_o + 16'(s_axis_tdata);
`endif
                end else begin
                    err_o[1] <= 1'b1;
                end
            end

`ifdef FW_TX_CHECKSUM_EN
            if ((r_state == S_MARK) && !w_trl_done) begin
                fw_tvalid_o <= 1'b1;
                fw_tdata_o  <= r_trl[0] ? csum_o[15:8] : csum_o[7:0];
                r_trl       <= r_trl + 2'd1;
            end
`endif

            if ((r_state == S_ACK) && (w_state_nxt == S_HOLD) && !w_ack)
                err_o[2] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fw_stream_tx.sv
// Scoreboard bench for fw_stream_tx: expected bytes queued as beats are accepted, popped on fw_tvalid_o.
module tb_fw_stream_tx;

    localparam int unsigned MAX_LEN     = 16;
    localparam int unsigned SETUP_CYC   = 8;
    localparam int unsigned HOLD_CYC    = 8;
    localparam int unsigned MARK_GAP    = 4;
    localparam int unsigned ACK_TIMEOUT = 64;
    localparam int unsigned LEN_W       = $clog2(MAX_LEN) + 1;

    logic             aclk = 1'b0;
    logic             aclk_rst = 1'b1;
    logic             run_active_i = 1'b0;
    logic             start_i = 1'b0;
    logic             bank_i = 1'b0;
    logic [7:0]       s_axis_tdata = 8'h00;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tready;
    logic             s_axis_tlast = 1'b0;
    logic             fw_loading_o;
    logic [7:0]       fw_tdata_o;
    logic             fw_tvalid_o;
    logic [1:0]       fw_mark_o;
    logic [1:0]       fwmon_wr_i = 2'b00;
    logic             busy_o;
    logic             done_o;
    logic [2:0]       err_o;
    logic [LEN_W-1:0] byte_cnt_o;
`ifdef FW_TX_CHECKSUM_EN
    logic [15:0]      csum_o;
`endif

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_mark = -1000;
    int         mark_cnt = 0;
    logic [1:0] exp_mark = 2'b00;
    logic [7:0] exp_q[$];
    logic [15:0] m_csum = 16'h0000;

    fw_stream_tx #(
        .MAX_LEN(MAX_LEN), .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC),
        .MARK_GAP(MARK_GAP), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .aclk_i(aclk), .aclk_rst_i(aclk_rst), .run_active_i(run_active_i),
        .start_i(start_i), .bank_i(bank_i),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .fw_loading_o(fw_loading_o), .fw_tdata_o(fw_tdata_o), .fw_tvalid_o(fw_tvalid_o),
        .fw_mark_o(fw_mark_o), .fwmon_wr_i(fwmon_wr_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
`ifdef FW_TX_CHECKSUM_EN
        .csum_o(csum_o),
`endif
        .byte_cnt_o(byte_cnt_o)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Output stream scoreboard
    always @(negedge aclk) begin
        if (!aclk_rst && fw_tvalid_o) begin
            check("tv_in_load", 32'(fw_loading_o), 32'd1);
            if (exp_q.size() == 0) check("fw_extra_beat", 32'(fw_tvalid_o), 32'd0);
            else                   check("fw_tdata", 32'(fw_tdata_o), 32'(exp_q.pop_front()));
        end
    end

    // Mark bank, spacing and separation from data beats
    always @(negedge aclk) begin
        if (!aclk_rst && fw_mark_o != 2'b00) begin
            check("mark_bank", 32'(fw_mark_o), 32'(exp_mark));
            check("mark_gap", 32'(cyc - last_mark > int'(MARK_GAP)), 32'd1);
            check("mark_tv_overlap", 32'(fw_tvalid_o), 32'd0);
            last_mark = cyc;
            mark_cnt++;
        end
    end

    task automatic pulse_start(input logic b, input logic ra);
        @(posedge aclk); #1;
        start_i = 1'b1; bank_i = b; run_active_i = ra;
        @(posedge aclk); #1;
        start_i = 1'b0;
    endtask

    task automatic begin_load(input logic b);
        exp_mark = b ? 2'b10 : 2'b01;
        mark_cnt = 0;
        m_csum   = 16'h0000;
        pulse_start(b, 1'b0);
    endtask

    task automatic send(input int n, input logic [7:0] base, input logic [7:0] step,
                        input bit gaps, input bit last);
        int  cnt = 0;
        bit  got;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + 8'(i) * step;
            s_axis_tlast  = last && (i == n - 1);
            got = 1'b0;
            for (int t = 0; t < 100 && !got; t++) begin
                @(negedge aclk);
                got = s_axis_tready;
                @(posedge aclk); #1;
            end
            if (!got) begin
                check("tready_timeout", 32'(s_axis_tready), 32'd1);
                s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
                return;
            end
            if (cnt < int'(MAX_LEN)) begin
                exp_q.push_back(s_axis_tdata);
                m_csum = m_csum + 16'(s_axis_tdata);
            end
            cnt++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
`ifdef FW_TX_CHECKSUM_EN
        if (last) begin
            exp_q.push_back(m_csum[7:0]);
            exp_q.push_back(m_csum[15:8]);
        end
`endif
    endtask

    // d>0: ack bank in cycle mark+d (other bank driven before it if wrong); d==0: never ack
    task automatic finish_load(input logic b, input int d, input bit wrong,
                               input logic [2:0] exp_err, input int exp_cnt);
        int m  = -1;
        int dc = -1;
        int lat;
        for (int t = 0; t < 200 && m < 0; t++) begin
            @(negedge aclk);
            if (fw_mark_o != 2'b00) m = cyc;
        end
        if (m < 0) begin
            check("mark_timeout", 32'(fw_mark_o), 32'(exp_mark));
            return;
        end
        for (int i = 1; i <= d; i++) begin
            @(posedge aclk); #1;
            if (i == d)     fwmon_wr_i = b ? 2'b10 : 2'b01;
            else if (wrong) fwmon_wr_i = b ? 2'b01 : 2'b10;
            else            fwmon_wr_i = 2'b00;
        end
        if (d > 0) begin @(posedge aclk); #1; fwmon_wr_i = 2'b00; end
        for (int t = 0; t < int'(ACK_TIMEOUT + HOLD_CYC) + 50 && dc < 0; t++) begin
            @(negedge aclk);
            if (done_o) dc = cyc;
        end
        if (dc < 0) begin
            check("done_timeout", 32'(done_o), 32'd1);
            return;
        end
        lat = ((d > 0) ? d : int'(ACK_TIMEOUT) - 1) + 1 + int'(HOLD_CYC);
        check("done_latency", 32'(dc - m), 32'(lat));
        check("err", 32'(err_o), 32'(exp_err));
        check("byte_cnt", 32'(byte_cnt_o), 32'(exp_cnt));
        check("loading_at_done", 32'(fw_loading_o), 32'd0);
        check("busy_at_done", 32'(busy_o), 32'd0);
        check("q_drained", 32'(exp_q.size()), 32'd0);
        check("mark_count", 32'(mark_cnt), 32'd1);
`ifdef FW_TX_CHECKSUM_EN
        check("csum", 32'(csum_o), 32'(m_csum));
`endif
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_loading", 32'(fw_loading_o), 32'd0);
        check("rst_tvalid", 32'(fw_tvalid_o), 32'd0);
        check("rst_mark", 32'(fw_mark_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_cnt", 32'(byte_cnt_o), 32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        aclk_rst = 1'b0;

        // Full-length load to bank 1; stray start and run_active while busy are ignored
        begin_load(1'b1);
        @(negedge aclk);
        check("setup_loading", 32'(fw_loading_o), 32'd1);
        check("setup_busy", 32'(busy_o), 32'd1);
        check("setup_tready", 32'(s_axis_tready), 32'd0);
        pulse_start(1'b0, 1'b1);
        send(16, 8'h00, 8'h01, 1'b0, 1'b1);
        finish_load(1'b1, 3, 1'b0, 3'b000, 16);
        run_active_i = 1'b0;

        // Refused start during a run
        pulse_start(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            check("refused_busy", 32'(busy_o | fw_loading_o), 32'd0);
        end
        check("refused_err", 32'(err_o), 32'd1);
        run_active_i = 1'b0;

        // Overlength: 20 bytes into a 16-byte load
        begin_load(1'b0);
        send(20, 8'h40, 8'h01, 1'b1, 1'b1);
        finish_load(1'b0, 1, 1'b0, 3'b010, 16);

        // No acknowledge: timeout
        begin_load(1'b1);
        send(3, 8'hA0, 8'h05, 1'b0, 1'b1);
        finish_load(1'b1, 0, 1'b0, 3'b100, 3);

        // Back-to-back single-byte loads; wrong-bank ack ignored on bank 1
        begin_load(1'b0);
        send(1, 8'h5A, 8'h01, 1'b1, 1'b1);
        finish_load(1'b0, 2, 1'b0, 3'b000, 1);
        begin_load(1'b1);
        send(1, 8'hC3, 8'h01, 1'b1, 1'b1);
        finish_load(1'b1, 6, 1'b1, 3'b000, 1);

`ifdef FW_TX_CHECKSUM_EN
        begin_load(1'b0);
        send(2, 8'hFF, 8'h03, 1'b0, 1'b1);
        check("csum_model", 32'(m_csum), 32'h0101);
        finish_load(1'b0, 2, 1'b0, 3'b000, 2);
`endif

        // Async reset mid-stream: outputs drop at once, bank never marked
        begin_load(1'b0);
        send(3, 8'h11, 8'h01, 1'b0, 1'b0);
        @(posedge aclk); #3;
        aclk_rst = 1'b1;
        #1;
        check("arst_loading", 32'(fw_loading_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_tready", 32'(s_axis_tready), 32'd0);
        exp_q.delete();
        @(posedge aclk); #1;
        aclk_rst = 1'b0;
        repeat (30) @(posedge aclk);
        @(negedge aclk);
        check("arst_no_mark", 32'(mark_cnt), 32'd0);
        check("arst_idle", 32'(fw_loading_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
